data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
Data-memory block directly downstream of the core's MEM stage. It consumes the core's mem_in_s request plus byte address and returns mem_out_s responses, using a two-sided valid/yumi handshake. It services one LW/LBU/SW/SB at a time with a parameterised access latency, so the core's mem_stage stall logic is exercised realistically.

Parameters:
addr_width_p, 10, word-address bits; memory depth = 2^addr_width_p 32-bit words
latency_p, 2, cycles from request acceptance to first response valid (legal range 1..15)

Ports:
clk  input  1  single clock; all state updates on posedge
reset  input  1  synchronous, active-high; sampled on posedge clk
to_mem_i  input  $bits(mem_in_s)  core request: write_data[31:0], valid, wen, byte_not_word, yumi (response acknowledge)
data_mem_addr_i  input  32  byte address accompanying to_mem_i
from_mem_o  output  $bits(mem_out_s)  response: read_data[31:0], valid, yumi (request accept)

Behaviour:
- States: IDLE, BUSY, RESP. Reset -> IDLE, lat_cnt=0, latched request cleared, from_mem_o all zero. Memory array contents are not reset.
- IDLE: from_mem_o.yumi = to_mem_i.valid, combinationally, in the same cycle. On accept, latch wen, byte_not_word, write_data, word index = addr[2+:addr_width_p] and lane = addr[1:0]. Then set lat_cnt = latency_p-1 and go to BUSY.
- Address bits above 2+addr_width_p are ignored, so addresses wrap modulo depth. For word ops, addr[1:0] is ignored.
- BUSY: from_mem_o.yumi=0. Decrement lat_cnt each cycle. When lat_cnt==0, perform the array access in that cycle, load resp_data, and go to RESP.
  - Word write: writes all 32 bits.
  - Byte write: writes write_data[7:0] into lane only; other lanes are untouched.
  - Word read: returns the full word.
  - Byte read: returns zero-extended lane byte {24'b0, byte}.
  - Write response: read_data = 32'b0.
- Latency: request accepted in cycle T gives from_mem_o.valid first high in cycle T+latency_p.
- RESP: from_mem_o.valid=1. read_data is held stable until to_mem_i.yumi=1. On the yumi cycle go to IDLE; valid=0 from the next cycle.
  - No new request is accepted in RESP or on the yumi cycle (from_mem_o.yumi=0). The earliest next accept is T_yumi+1.
- to_mem_i.valid while BUSY/RESP is ignored; the core must hold it.
- to_mem_i.yumi outside RESP is ignored.
- Reset in any state (including mid-BUSY): return to IDLE next cycle. A write not yet performed is discarded. A write already performed stays in the array.
- Reset asserted together with to_mem_i.valid: the request is not accepted and from_mem_o.yumi=0 (reset has priority).
- Read and write data match the core's rf_wd/write_data width (32 bits). The array is a single port with one access per request, so there is no read/write collision.

Decomposition:
- mem_in_s and mem_out_s stay in the shared definitions package, unchanged.
- Add dmem_state_e {IDLE_D, BUSY_D, RESP_D} to the package. State names are suffixed to avoid colliding with the core state_e.
- One sub-module: dmem_array (2^addr_width_p x 32, byte-enable write, combinational read, no reset). The controller FSM, latency counter, lane select and zero-extend stay in data_mem_ctrl.

Test Plan:
- Word write/read, latency_p=2:
  - SW 0xDEADBEEF @0x40 accepted at T -> valid at T+2, read_data=0.
  - After yumi, LW @0x40 -> read_data=0xDEADBEEF at accept+2.
- Byte merge:
  - Word 0x11223344 @0x10, then SB data 0xAB @0x12 -> LW @0x10 returns 0x11AB3344.
  - LBU @0x12 returns 0x000000AB, and LBU @0x13 returns 0x00000011.
- Back-pressure: hold to_mem_i.yumi=0 for 5 cycles in RESP -> valid stays 1 and read_data is constant. Yumi on cycle 6 -> valid=0 next cycle. A new valid on the yumi cycle is accepted only one cycle later.
- Wrap and latency sweep, latency_p in {1,4}, addr_width_p=10:
  - SW @0x1004 then LW @0x0004 -> same word.
  - valid arrives exactly latency_p cycles after accept.
- Reset mid-BUSY (latency_p=4): SW @0x20 accepted, reset asserted 1 cycle later -> IDLE, no valid is produced, and LW @0x20 returns the prior contents.
- Reset with valid: reset=1 and to_mem_i.valid=1 in the same cycle -> from_mem_o.yumi=0 and from_mem_o=0 next cycle.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared request/response payloads and controller state encoding for the data memory.
package data_mem_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned LAT_W  = 4;

    // Core request toward the data memory; yumi acknowledges a response.
    typedef struct packed {
        logic [DATA_W-1:0] write_data;
        logic              valid;
        logic              wen;
        logic              byte_not_word;
        logic              yumi;
    } mem_in_s;

    // Memory response toward the core; yumi accepts a request.
    typedef struct packed {
        logic [DATA_W-1:0] read_data;
        logic              valid;
        logic              yumi;
    } mem_out_s;

    typedef enum logic [1:0] {
        IDLE_D,
        BUSY_D,
        RESP_D
    } dmem_state_e;

    // One-hot byte enable for a lane within a word.
    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] lane);
        return LANES'(1) << lane;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core-to-data-memory bus: request, byte address and response.
interface data_mem_ctrl_if;
    import data_mem_ctrl_pkg::*;

    mem_in_s     to_mem_i;
    logic [31:0] data_mem_addr_i;
    mem_out_s    from_mem_o;

    modport master (output to_mem_i, output data_mem_addr_i, input from_mem_o);
    modport slave  (input to_mem_i, input data_mem_addr_i, output from_mem_o);
endinterface

// File: rtl/data_mem_ctrl_dmem_array.sv
// Single-port word array with byte-enable write and combinational read; contents not reset.
module dmem_array
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned addr_width_p = 10
) (
    input  logic                    clk,
    input  logic [addr_width_p-1:0] addr_i,
    input  logic [LANES-1:0]        be_i,
    input  logic [DATA_W-1:0]       wdata_i,
    output logic [DATA_W-1:0]       rdata_o
);

    localparam int unsigned DEPTH = 2 ** addr_width_p;

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write; untouched lanes keep their contents.
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(LANES); b++) begin
            if (be_i[b]) begin
                mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: accepts one request at a time, waits latency_p cycles, then holds the response until acknowledged.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned addr_width_p = 10,
    parameter int unsigned latency_p    = 2
) (
    input  logic            clk,
    input  logic            reset,
    data_mem_ctrl_if.slave  mem_if
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(latency_p - 1);

    dmem_state_e             state_q, state_d;
    logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;
    logic                    wen_q, wen_d;
    logic                    bnw_q, bnw_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [addr_width_p-1:0] idx_q, idx_d;
    logic [1:0]              lane_q, lane_d;
    logic [DATA_W-1:0]       resp_q, resp_d;

    logic                    accept_c;
    logic                    access_c;
    logic                    cur_wen_c;
    logic                    cur_bnw_c;
    logic [DATA_W-1:0]       cur_wdata_c;
    logic [addr_width_p-1:0] cur_idx_c;
    logic [1:0]              cur_lane_c;
    logic [LANES-1:0]        arr_be_c;
    logic [DATA_W-1:0]       arr_wdata_c;
    logic [DATA_W-1:0]       arr_rdata_c;
    mem_out_s                from_mem_c;
    logic                    unused_addr_c;

    // Address bits above the word index are dropped so accesses wrap modulo depth.
    assign unused_addr_c = ^mem_if.data_mem_addr_i[31:2+addr_width_p];

    // State register and latched request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE_D;
            lat_cnt_q <= '0;
            wen_q     <= 1'b0;
            bnw_q     <= 1'b0;
            wdata_q   <= '0;
            idx_q     <= '0;
            lane_q    <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            wen_q     <= wen_d;
            bnw_q     <= bnw_d;
            wdata_q   <= wdata_d;
            idx_q     <= idx_d;
            lane_q    <= lane_d;
            resp_q    <= resp_d;
        end
    end

    // Next state, latency countdown and the single array access per request.
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        wen_d       = wen_q;
        bnw_d       = bnw_q;
        wdata_d     = wdata_q;
        idx_d       = idx_q;
        lane_d      = lane_q;
        resp_d      = resp_q;
        accept_c    = 1'b0;
        access_c    = 1'b0;
        cur_wen_c   = wen_q;
        cur_bnw_c   = bnw_q;
        cur_wdata_c = wdata_q;
        cur_idx_c   = idx_q;
        cur_lane_c  = lane_q;

        unique case (state_q)
            IDLE_D: begin
                // With a one-cycle latency the access uses the live request directly.
                cur_wen_c   = mem_if.to_mem_i.wen;
                cur_bnw_c   = mem_if.to_mem_i.byte_not_word;
                cur_wdata_c = mem_if.to_mem_i.write_data;
                cur_idx_c   = mem_if.data_mem_addr_i[2 +: addr_width_p];
                cur_lane_c  = mem_if.data_mem_addr_i[1:0];
                if (mem_if.to_mem_i.valid) begin
                    accept_c  = 1'b1;
                    wen_d     = cur_wen_c;
                    bnw_d     = cur_bnw_c;
                    wdata_d   = cur_wdata_c;
                    idx_d     = cur_idx_c;
                    lane_d    = cur_lane_c;
                    lat_cnt_d = LAT_INIT;
                    if (LAT_INIT == '0) begin
                        access_c = 1'b1;
                        state_d  = RESP_D;
                    end else begin
                        state_d  = BUSY_D;
                    end
                end
            end
            BUSY_D: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (lat_cnt_q == LAT_W'(1)) begin
                    access_c = 1'b1;
                    state_d  = RESP_D;
                end
            end
            RESP_D: begin
                if (mem_if.to_mem_i.yumi) begin
                    state_d = IDLE_D;
                end
            end
            default: state_d = IDLE_D;
        endcase

        if (access_c) begin
            if (cur_wen_c) begin
                resp_d = '0;
            end else if (cur_bnw_c) begin
                resp_d = {24'b0, arr_rdata_c[8*cur_lane_c +: 8]};
            end else begin
                resp_d = arr_rdata_c;
            end
        end
    end

    // Byte writes replicate the low byte and enable only the addressed lane.
    always_comb begin
        arr_wdata_c = cur_bnw_c ? {LANES{cur_wdata_c[7:0]}} : cur_wdata_c;
        arr_be_c    = '0;
        if (access_c && cur_wen_c && !reset) begin
            arr_be_c = cur_bnw_c ? lane_mask(cur_lane_c) : {LANES{1'b1}};
        end
    end

    // Response bus; request accept is combinational and suppressed by reset.
    always_comb begin
        from_mem_c           = '0;
        from_mem_c.read_data = resp_q;
        from_mem_c.valid     = (state_q == RESP_D);
        from_mem_c.yumi      = accept_c && !reset;
    end

    assign mem_if.from_mem_o = from_mem_c;

    dmem_array #(
        .addr_width_p (addr_width_p)
    ) u_array (
        .clk     (clk),
        .addr_i  (cur_idx_c),
        .be_i    (arr_be_c),
        .wdata_i (arr_wdata_c),
        .rdata_o (arr_rdata_c)
    );

endmodule
